// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Program-counter register plus a small instruction-fetch sequencer.
//
//  * PC is written from newPC on PCWrite, or on PCWriteCond when Zero is set.
//    A PC write is allowed at any time, including while a fetch is in flight.
//  * On fetchStart (sampled in IDLE, or in FAULT when the timeout feature is
//    built in), the current PC is latched into imemAddr. The fetch then waits
//    in REQ for imemAck. When the ack arrives, the returned word is latched
//    into IR and irValid pulses for one cycle.
//
// Optional feature, enabled by defining FETCH_TIMEOUT_EN:
//  A REQ that sees no ack for TIMEOUT cycles moves to FAULT, drops imemReq and
//  raises the sticky fetchFault flag. fetchStart in FAULT clears the flag and
//  reissues the fetch at the current PC. Without the macro there is no
//  counter and no FAULT state, and fetchFault is tied to 0.
//
// Handshake (imem side): imemReq is held high for the whole REQ state, and
// imemAddr stays stable while imemReq=1. The transfer happens on the rising
// edge where imemReq=1 and imemAck=1. imemAck outside REQ is ignored.
//
// Parameters:
//  ADDR_W    width of PC, newPC, imemAddr, imemData, IR
//  RESET_PC  PC (and imemAddr) value after reset
//  TIMEOUT   REQ cycles without ack before a fault (FETCH_TIMEOUT_EN only)
//
// Ports:
//  clk, rst_n             clock (rising edge), async active-low reset
//  newPC                  next PC from the PC-source mux
//  PCWrite                unconditional PC write enable
//  PCWriteCond, Zero      branch PC write enable, qualified by Zero
//  fetchStart             start a fetch at the current PC
//  imemAck, imemData      instruction memory ack and read data
//  imemReq, imemAddr      instruction memory request and address
//  PC, IR                 program counter and instruction register
//  irValid                one-cycle pulse: IR updated this cycle
//  fetchBusy              state is not IDLE
//  fetchFault             fetch timeout flag
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] newPC,
    input  logic              PCWrite,
    input  logic              PCWriteCond,
    input  logic              Zero,
    input  logic              fetchStart,
    input  logic              imemAck,
    input  logic [ADDR_W-1:0] imemData,
    output logic              imemReq,
    output logic [ADDR_W-1:0] imemAddr,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] IR,
    output logic              irValid,
    output logic              fetchBusy,
    output logic              fetchFault
);

`ifdef FETCH_TIMEOUT_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FAULT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1
    } state_t;
`endif

    state_t state, state_next;

    logic              pc_we;
    logic              start_fetch;
    logic              complete;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] ir_q;
    logic              ir_valid_q;

`ifdef FETCH_TIMEOUT_EN
    localparam int                CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_plus;
    logic             cnt_inc;
    logic             fault_set;
    logic             fault_clr;
    logic             fault_q;

    assign cnt_plus = cnt_q + 1'b1;
`endif

    assign pc_we = PCWrite | (PCWriteCond & Zero);

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and control decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        start_fetch = 1'b0;
        complete    = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        cnt_inc     = 1'b0;
        fault_set   = 1'b0;
        fault_clr   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (fetchStart) begin
                    start_fetch = 1'b1;
                    state_next  = REQ;
                end
            end
            REQ: begin
                // An ack always completes the fetch, even on the cycle the
                // timeout count would expire.
                if (imemAck) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (cnt_plus == TIMEOUT_C) begin
                    fault_set  = 1'b1;
                    state_next = FAULT;
                end else begin
                    cnt_inc = 1'b1;
                end
`endif
            end
`ifdef FETCH_TIMEOUT_EN
            FAULT: begin
                if (fetchStart) begin
                    start_fetch = 1'b1;
                    fault_clr   = 1'b1;
                    state_next  = REQ;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // PC register: independent of the fetch sequencer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (pc_we) begin
            pc_q <= newPC;
        end
    end

    // -------------------------------------------------------------------------
    // Fetch datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= RESET_PC;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            // pc_q here is the value before any PC write on this same edge,
            // so a fetch started together with a PC write uses the old PC.
            if (start_fetch) begin
                addr_q <= pc_q;
            end
            if (complete) begin
                ir_q <= imemData;
            end
            ir_valid_q <= complete;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            if (start_fetch) begin
                cnt_q <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_plus;
            end
            if (fault_set) begin
                fault_q <= 1'b1;
            end else if (fault_clr) begin
                fault_q <= 1'b0;
            end
        end
    end

    assign fetchFault = fault_q;
`else
    assign fetchFault = 1'b0;
`endif

    // imemReq comes straight from the state register, so an async reset
    // drops it immediately.
    assign imemReq   = (state == REQ);
    assign fetchBusy = (state != IDLE);
    assign imemAddr  = addr_q;
    assign PC        = pc_q;
    assign IR        = ir_q;
    assign irValid   = ir_valid_q;

endmodule
